audio_dac_out: RTL and testbench

Output stage downstream of the audio copper (`acp`): consumes its 8-bit unsigned sample word `audio_out[7:0]` and converts it to a single-bit PWM or first-order sigma-delta stream for an RC-filtered audio pin. The block resamples the copper output at a fixed sample rate derived from the 50 MHz system clock. Sample updates are glitch-free: in PWM mode a new sample never changes duty mid-period.

---
 rtl/audio_pkg.sv | 11 +
 rtl/audio_dac_out_sample_rate_div.sv | 33 +++
 rtl/audio_dac_out.sv | 109 ++++++++++
 tb/tb_audio_dac_out.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants for the audio output path.
// Provides the mode encodings, the copper sample width and the
// 44.1 kHz divider value for a 50 MHz system clock.
package audio_pkg;

   localparam logic MODE_PWM       = 1'b0;
   localparam logic MODE_SD        = 1'b1;
   localparam int   AUDIO_WIDTH    = 8;
   localparam int   SAMPLE_DIV_44K = 1134;

endpackage

// File: rtl/audio_dac_out_sample_rate_div.sv
// sample_rate_div: free-running divider that produces the sample tick.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   tick - high for the single cycle in which the count sits at DIV-1
module sample_rate_div import audio_pkg::*; #(
   parameter int DIV = SAMPLE_DIV_44K
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_divCnt;

   // Count 0..DIV-1 and wrap; runs continuously so the sample grid
   // never drifts regardless of what the consumer is doing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_divCnt <= '0;
      end else if (r_divCnt == LAST) begin
         r_divCnt <= '0;
      end else begin
         r_divCnt <= r_divCnt + CW'(1);
      end
   end

   assign tick = (r_divCnt == LAST);

endmodule

// File: rtl/audio_dac_out.sv
// audio_dac_out: turns the copper's unsigned sample word into a 1-bit
// PWM or first-order sigma-delta stream for an RC-filtered pin.
// Ports:
//   clk           - 50 MHz system clock
//   rst           - asynchronous active-high reset
//   audio_in      - unsigned sample (quasi-static, sampled on latch cycles)
//   en            - output enable, taken at period boundaries
//   mode          - 0 = PWM, 1 = sigma-delta, taken at period boundaries
//   dac_out       - registered 1-bit audio stream
//   sample_strobe - one-cycle pulse the cycle after a new sample latches
module audio_dac_out import audio_pkg::*; #(
   parameter int WIDTH      = AUDIO_WIDTH,
   parameter int SAMPLE_DIV = SAMPLE_DIV_44K
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] audio_in,
   input  logic             en,
   input  logic             mode,
   output logic             dac_out,
   output logic             sample_strobe
);

   logic [WIDTH-1:0] r_pwmCnt;
   logic [WIDTH-1:0] r_curSample;
   logic [WIDTH-1:0] r_acc;
   logic             r_pending;
   logic             r_mode;
   logic             r_en;
   logic             r_dacOut;
   logic             r_strobe;

   logic             w_tick;
   logic             w_boundary;
   logic             w_latch;
   logic             w_modeNext;
   logic             w_enNext;
   logic [WIDTH-1:0] w_sampleNext;
   logic [WIDTH-1:0] w_pwmNext;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_accNext;
   logic             w_bit;

   sample_rate_div #(
      .DIV (SAMPLE_DIV)
   ) u_sampleDiv (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   // Next-state decode. Everything that must not change mid-period
   // (sample, enable, mode) only moves at a boundary, and dac_out is
   // computed from those next values so the new period starts cleanly.
   // A tick landing on a boundary latches straight away; in sigma-delta
   // every cycle is a boundary, giving zero-latency latching.
   always_comb begin
      w_boundary   = (r_mode == MODE_SD) || (r_pwmCnt == '1);
      w_latch      = w_boundary && (r_pending || w_tick);
      w_modeNext   = w_boundary ? mode : r_mode;
      w_enNext     = w_boundary ? en : r_en;
      w_sampleNext = w_latch ? audio_in : r_curSample;
      w_pwmNext    = r_pwmCnt + WIDTH'(1);
      w_sum        = {1'b0, r_acc} + {1'b0, r_curSample};
      w_accNext    = r_acc;
      w_bit        = 1'b0;
      if (w_modeNext != r_mode) begin
         w_accNext = '0;
      end else if (r_mode == MODE_SD) begin
         w_accNext = w_sum[WIDTH-1:0];
         w_bit     = w_sum[WIDTH];
      end else begin
         w_bit     = (w_pwmNext < w_sampleNext);
      end
   end

   // State update. The PWM counter free-runs in both modes so a return
   // to PWM lines up with the same period grid. A second tick while a
   // latch is still pending simply keeps pending set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pwmCnt    <= '0;
         r_curSample <= '0;
         r_acc       <= '0;
         r_pending   <= 1'b0;
         r_mode      <= MODE_PWM;
         r_en        <= 1'b0;
         r_dacOut    <= 1'b0;
         r_strobe    <= 1'b0;
      end else begin
         r_pwmCnt    <= w_pwmNext;
         r_curSample <= w_sampleNext;
         r_acc       <= w_accNext;
         r_mode      <= w_modeNext;
         r_en        <= w_enNext;
         r_strobe    <= w_latch;
         r_dacOut    <= w_enNext & w_bit;
         if (w_latch) begin
            r_pending <= 1'b0;
         end else if (w_tick) begin
            r_pending <= 1'b1;
         end
      end
   end

   assign dac_out       = r_dacOut;
   assign sample_strobe = r_strobe;

endmodule

// File: tb/tb_audio_dac_out.sv
// Testbench for audio_dac_out with a 300-clock sample period.
// Expected strobe cycles are pushed into a queue when each scenario is
// set up and popped by a monitor whenever the DUT raises sample_strobe;
// duty and density windows are compared against values from the sample.
module tb_audio_dac_out;

   localparam int W      = 8;
   localparam int DIV    = 300;
   localparam int PERIOD = 256;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] audio_in = '0;
   logic         en = 1'b0;
   logic         mode = 1'b0;
   logic         dac_out;
   logic         sample_strobe;

   int checks = 0;
   int errors = 0;
   int cyc;
   bit sbActive = 1'b0;
   int expStrobe[$];

   audio_dac_out #(
      .WIDTH      (W),
      .SAMPLE_DIV (DIV)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .audio_in      (audio_in),
      .en            (en),
      .mode          (mode),
      .dac_out       (dac_out),
      .sample_strobe (sample_strobe)
   );

   // 100 MHz-style bench clock; only the cycle count matters.
   always #5 clk = ~clk;

   // Cycle index since reset release; equals the PWM counter phase and
   // the divider phase used to predict ticks and boundaries.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic checkOutput(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // PWM: the k-th tick latches at the first boundary (phase 255) at or
   // after the tick, and the strobe shows one cycle later.
   function automatic int pwmStrobeCyc(input int k);
      int t;
      t = DIV * (k + 1) - 1;
      return t + (PERIOD - 1 - (t % PERIOD)) + 1;
   endfunction

   // Sigma-delta: latch on the tick itself, strobe next cycle.
   function automatic int sdStrobeCyc(input int k);
      return DIV * (k + 1);
   endfunction

   // Scoreboard pop: every strobe must match the oldest expected cycle.
   always @(negedge clk) begin
      if (sbActive && !rst && sample_strobe) begin
         int exp;
         exp = (expStrobe.size() > 0) ? expStrobe.pop_front() : -1;
         checkOutput("strobeCycle", cyc, exp);
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic [W-1:0] a, input logic e, input logic m);
      sbActive = 1'b0;
      expStrobe.delete();
      rst      = 1'b1;
      audio_in = a;
      en       = e;
      mode     = m;
      repeat (3) @(negedge clk);
      rst      = 1'b0;
      sbActive = 1'b1;
   endtask

   task automatic waitCyc(input int n);
      int guard = 0;
      while (cyc < n && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20000) checkOutput("waitTimeout", cyc, n);
   endtask

   task automatic measureWindow(input int start, input int len, output int highs, output int pairs);
      logic prev = 1'b0;
      highs = 0;
      pairs = 0;
      waitCyc(start);
      for (int i = 0; i < len; i++) begin
         if (dac_out === 1'b1) highs++;
         if (dac_out === 1'b1 && prev === 1'b1) pairs++;
         prev = dac_out;
         @(negedge clk);
      end
   endtask

   initial begin
      int highs;
      int pairs;
      int pairs2;

      // Reset in the middle of a high PWM phase.
      applyStimulus(8'hC0, 1'b1, 1'b0);
      expStrobe.push_back(pwmStrobeCyc(0));
      waitCyc(600);
      checkOutput("preResetDac", int'(dac_out), 1);
      #2;
      rst = 1'b1;
      sbActive = 1'b0;
      #1;
      checkOutput("resetDac", int'(dac_out), 0);
      checkOutput("resetStrobe", int'(sample_strobe), 0);

      // First latch after reset, then duty for 0xC0, 0x40, 0x00, 0xFF.
      applyStimulus(8'hC0, 1'b1, 1'b0);
      for (int k = 0; k < 7; k++) expStrobe.push_back(pwmStrobeCyc(k));
      measureWindow(512, PERIOD, highs, pairs);
      checkOutput("dutyC0", highs, 192);
      audio_in = 8'h40;
      measureWindow(1024, PERIOD, highs, pairs);
      checkOutput("duty40", highs, 64);
      audio_in = 8'h00;
      measureWindow(1536, PERIOD, highs, pairs);
      checkOutput("duty00", highs, 0);
      audio_in = 8'hFF;
      measureWindow(2048, PERIOD, highs, pairs);
      checkOutput("dutyFF", highs, 255);
      waitCyc(2310);
      checkOutput("strobeDrainDuty", expStrobe.size(), 0);

      // Sample change at pwm phase 100 just after a tick stays out of
      // the running period.
      applyStimulus(8'h20, 1'b1, 1'b0);
      for (int k = 0; k < 9; k++) expStrobe.push_back(pwmStrobeCyc(k));
      fork
         measureWindow(2304, PERIOD, highs, pairs);
         begin
            waitCyc(2404);
            audio_in = 8'hE0;
         end
      join
      checkOutput("glitchFreeOld", highs, 32);
      measureWindow(2560, PERIOD, highs, pairs);
      checkOutput("glitchFreeNew", highs, 224);
      waitCyc(2820);
      checkOutput("strobeDrainChange", expStrobe.size(), 0);

      // Sigma-delta density and isolated ones for 0x55.
      applyStimulus(8'h55, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) expStrobe.push_back(sdStrobeCyc(k));
      measureWindow(400, PERIOD, highs, pairs);
      checkOutput("sdDensityA", highs, 85);
      measureWindow(656, PERIOD, highs, pairs2);
      checkOutput("sdDensityB", highs, 85);
      checkOutput("sdRunLength", pairs + pairs2, 0);
      waitCyc(910);
      checkOutput("strobeDrainSd", expStrobe.size(), 0);

      // Enable drop mid-period, then re-enable with a newer sample.
      applyStimulus(8'h80, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) expStrobe.push_back(pwmStrobeCyc(k));
      fork
         measureWindow(512, PERIOD, highs, pairs);
         begin
            waitCyc(522);
            en = 1'b0;
         end
      join
      checkOutput("enFallFinish", highs, 128);
      measureWindow(768, PERIOD, highs, pairs);
      checkOutput("disabledLow", highs, 0);
      waitCyc(1100);
      audio_in = 8'h30;
      en = 1'b1;
      measureWindow(1280, PERIOD, highs, pairs);
      checkOutput("reEnable", highs, 48);
      waitCyc(1540);
      checkOutput("strobeDrainEn", expStrobe.size(), 0);

      // PWM to sigma-delta request at pwm phase 50.
      applyStimulus(8'h40, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) expStrobe.push_back(pwmStrobeCyc(k));
      expStrobe.push_back(sdStrobeCyc(3));
      fork
         measureWindow(768, PERIOD, highs, pairs);
         begin
            waitCyc(818);
            mode = 1'b1;
            waitCyc(1023);
            checkOutput("modeAtBoundary", int'(dut.r_mode), 0);
         end
      join
      checkOutput("switchPeriodDuty", highs, 64);
      checkOutput("modeAfterSwitch", int'(dut.r_mode), 1);
      checkOutput("accAfterSwitch", int'(dut.r_acc), 0);
      measureWindow(1100, PERIOD, highs, pairs);
      checkOutput("sdDensityAfterSwitch", highs, 64);
      waitCyc(1360);
      checkOutput("strobeDrainSwitch", expStrobe.size(), 0);

      sbActive = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
